// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/PC word type, the IS bubble word and
// the fetch controller state encoding.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } if_state_t;

endpackage

// File: rtl/if_ctrl_if.sv
// Instruction memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface if_ctrl_if;
  import cpu_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/if_ctrl_chk.sv
// Protocol invariants of the fetch controller, kept apart from the design so
// they can be attached to any instance.
module if_ctrl_chk import cpu_pkg::*; (
  input logic  clk,
  input logic  rst,
  input logic  imem_req,
  input word_t imem_addr,
  input logic  imem_ack,
  input logic  flush,
  input logic  pc_en,
  input logic  ir_we,
  input logic  ir_valid
);

  a_valid_needs_we : assert property (@(posedge clk) disable iff (rst)
    ir_valid |-> ir_we);

  a_pc_en_on_accept : assert property (@(posedge clk) disable iff (rst)
    pc_en |-> (imem_req && imem_ack && !flush));

  // A flushed fetch that is still outstanding keeps its address until acked.
  a_drop_addr_stable : assert property (@(posedge clk)
    (!rst && imem_req && !imem_ack && flush) |=> (rst || (imem_addr == $past(imem_addr))));

endmodule

// File: rtl/if_ctrl.sv
// Fetch controller for the IS pipeline register: issues instruction memory
// requests, advances the PC and loads IS with instructions or bubbles.
module if_ctrl import cpu_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  word_t             pc,
  output logic              pc_en,
  if_ctrl_if.master         imem,
  input  logic              stall,
  input  logic              flush,
  output logic              ir_we,
  output word_t             ir_data,
  output logic              ir_valid
);

  if_state_t state_r;
  if_state_t state_nxt_s;
  word_t     addr_q;
  word_t     buf_q;
  logic      buf_load_s;

  // Next-state and output decode; flush outranks stall, DROP ignores flush.
  always_comb begin
    state_nxt_s    = state_r;
    imem.imem_req  = 1'b0;
    imem.imem_addr = addr_q;
    pc_en          = 1'b0;
    ir_we          = 1'b0;
    ir_data        = NOP_INSN;
    ir_valid       = 1'b0;
    buf_load_s     = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc;
        if (flush) begin
          ir_we = 1'b1;
          if (imem.imem_ack) begin
            state_nxt_s = REQ;
          end else begin
            state_nxt_s = DROP;
          end
        end else if (imem.imem_ack) begin
          pc_en = 1'b1;
          if (stall) begin
            buf_load_s  = 1'b1;
            state_nxt_s = HOLD;
          end else begin
            ir_we    = 1'b1;
            ir_data  = imem.imem_data;
            ir_valid = 1'b1;
          end
        end else if (stall) begin
          ir_we = 1'b0;
        end else begin
          ir_we = 1'b1;
        end
      end
      HOLD: begin
        if (flush) begin
          ir_we       = 1'b1;
          state_nxt_s = REQ;
        end else if (stall) begin
          state_nxt_s = HOLD;
        end else begin
          ir_we       = 1'b1;
          ir_data     = buf_q;
          ir_valid    = 1'b1;
          state_nxt_s = REQ;
        end
      end
      DROP: begin
        imem.imem_req = 1'b1;
        if (imem.imem_ack) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Address of the in-flight request, replayed while draining a flushed fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= 32'h0000_0000;
    end else if (state_r == REQ) begin
      addr_q <= pc;
    end else begin
      addr_q <= addr_q;
    end
  end

  // Hold buffer for an instruction that returns while IS is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= NOP_INSN;
    end else if (buf_load_s) begin
      buf_q <= imem.imem_data;
    end else begin
      buf_q <= buf_q;
    end
  end

endmodule

// File: tb/tb_if_ctrl.sv
// Bench for if_ctrl: PC register and variable-latency memory models plus a
// rule-level model of what IS must load each cycle.
module tb_if_ctrl;
  import cpu_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  word_t pc;
  logic  pc_en;
  logic  stall;
  logic  flush;
  logic  ir_we;
  word_t ir_data;
  logic  ir_valid;

  if_ctrl_if imem ();

  if_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .pc_en    (pc_en),
    .imem     (imem),
    .stall    (stall),
    .flush    (flush),
    .ir_we    (ir_we),
    .ir_data  (ir_data),
    .ir_valid (ir_valid)
  );

  if_ctrl_chk chk_i (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem.imem_req),
    .imem_addr (imem.imem_addr),
    .imem_ack  (imem.imem_ack),
    .flush     (flush),
    .pc_en     (pc_en),
    .ir_we     (ir_we),
    .ir_valid  (ir_valid)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fails  = 0;
  int    pcen_cnt = 0;
  // Reference model: pipeline just out of reset, a held instruction, and a
  // flushed-but-outstanding fetch that must be drained.
  bit    idle_m;
  bit    held_v;
  word_t held_w;
  bit    drop_m;
  word_t drop_addr;
  // Memory model.
  bit    busy;
  int    cnt;
  bit    ovr_en = 1'b0;
  word_t ovr_data;
  // Last sampled outputs, for scenario-specific checks.
  logic  obs_req, obs_we, obs_val;
  word_t obs_addr, obs_data;

  function automatic word_t mem_word(input word_t a);
    return 32'h2000_0000 + ((a >> 2) + 32'd1) * 32'h0001_0001;
  endfunction

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive controls, answer the memory, check, advance models.
  task automatic step(input logic s, input logic f, input word_t npc, input int lat);
    logic  ack, e_req, e_pcen, e_we, e_val;
    word_t dat, e_addr, e_data;
    stall = s;
    flush = f;
    #1;
    ack = 1'b0;
    if (imem.imem_req === 1'b1) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = lat;
      end
      ack = (cnt == 0);
    end
    dat = ack ? (ovr_en ? ovr_data : mem_word(imem.imem_addr)) : $urandom();
    imem.imem_ack  = ack;
    imem.imem_data = dat;

    e_req  = !idle_m && !held_v;
    e_addr = drop_m ? drop_addr : pc;
    e_pcen = ack && !f && !drop_m;
    e_we   = 1'b0;
    e_val  = 1'b0;
    e_data = NOP_INSN;
    if (idle_m || drop_m) begin
      e_we = 1'b0;
    end else if (f) begin
      e_we = 1'b1;
    end else if (s) begin
      e_we = 1'b0;
    end else if (held_v) begin
      e_we = 1'b1; e_val = 1'b1; e_data = held_w;
    end else if (ack) begin
      e_we = 1'b1; e_val = 1'b1; e_data = dat;
    end else begin
      e_we = 1'b1;
    end

    @(negedge clk);
    obs_req = imem.imem_req; obs_addr = imem.imem_addr;
    obs_we = ir_we; obs_val = ir_valid; obs_data = ir_data;
    chk("imem_req", imem.imem_req, e_req);
    if (e_req) chk("imem_addr", imem.imem_addr, e_addr);
    chk("pc_en", pc_en, e_pcen);
    chk("ir_we", ir_we, e_we);
    chk("ir_valid", ir_valid, e_val);
    chk("ir_data", ir_data, e_data);
    if (pc_en === 1'b1) pcen_cnt++;

    @(posedge clk);
    #1;
    if (ack) busy = 1'b0;
    else if (busy) cnt--;
    idle_m = 1'b0;
    if (drop_m) begin
      if (ack) drop_m = 1'b0;
    end else if (f) begin
      held_v = 1'b0;
      if (e_req && !ack) begin
        drop_m    = 1'b1;
        drop_addr = e_addr;
      end
    end else if (ack && s) begin
      held_v = 1'b1;
      held_w = dat;
    end else if (held_v && !s) begin
      held_v = 1'b0;
    end
    if (e_pcen) pc = pc + 32'd4;
    if (f) pc = npc;
  endtask

  // One reset cycle; the memory abandons any outstanding request.
  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    imem.imem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy = 1'b0; idle_m = 1'b1; held_v = 1'b0; drop_m = 1'b0;
  endtask

  initial begin
    pc = 32'h0000_0000;
    imem.imem_data = 32'h0000_0000;
    do_reset();

    // Zero-wait fetches at 0x0 and 0x4 after the IDLE cycle.
    step(1'b0, 1'b0, 32'd0, 0);
    chk("idle_req", obs_req, 32'd0);
    chk("idle_we", obs_we, 32'd0);
    step(1'b0, 1'b0, 32'd0, 0);
    chk("zw_insn0", obs_data, 32'h2001_0001);
    chk("zw_valid0", obs_val, 32'd1);
    step(1'b0, 1'b0, 32'd0, 0);
    chk("zw_insn1", obs_data, 32'h2002_0002);
    chk("zw_pcen_count", pcen_cnt, 32'd2);

    // 2-wait memory: two bubbles, then the instruction.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'd0, 2);
      if (i < 2) chk("w2_bubble", {obs_we, obs_val}, 32'd2);
    end
    chk("w2_insn", obs_data, mem_word(32'h0000_0008));

    // Ack in the first stall cycle, then held for three more stall cycles.
    pcen_cnt = 0; ovr_en = 1'b1; ovr_data = 32'h8C43_0010;
    step(1'b1, 1'b0, 32'd0, 0);
    ovr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 0);
      chk("hold_req", obs_req, 32'd0);
      chk("hold_we", obs_we, 32'd0);
    end
    step(1'b0, 1'b0, 32'd0, 0);
    chk("hold_release", obs_data, 32'h8C43_0010);
    chk("hold_valid", obs_val, 32'd1);
    chk("hold_pcen_once", pcen_cnt, 32'd1);
    step(1'b0, 1'b0, 32'd0, 0);

    // Flush while a 3-wait fetch at 0x10 is outstanding; redirect to 0x40.
    pc = 32'h0000_0010;
    step(1'b0, 1'b0, 32'd0, 3);
    step(1'b0, 1'b1, 32'h0000_0040, 0);
    chk("flush_nop_we", obs_we, 32'd1);
    chk("flush_nop_data", obs_data, NOP_INSN);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 32'd0, 0);
      chk("drop_addr", obs_addr, 32'h0000_0010);
      chk("drop_we", obs_we, 32'd0);
    end
    step(1'b0, 1'b0, 32'd0, 0);
    chk("redirect_addr", obs_addr, 32'h0000_0040);
    chk("redirect_insn", obs_data, mem_word(32'h0000_0040));

    // Flush together with stall while holding.
    step(1'b1, 1'b0, 32'd0, 0);
    step(1'b1, 1'b1, 32'h0000_0080, 0);
    chk("hold_flush_we", obs_we, 32'd1);
    chk("hold_flush_valid", obs_val, 32'd0);
    step(1'b0, 1'b0, 32'd0, 0);
    chk("hold_flush_req", obs_req, 32'd1);
    chk("hold_flush_addr", obs_addr, 32'h0000_0080);

    // Reset in the middle of an outstanding request.
    step(1'b0, 1'b0, 32'd0, 3);
    do_reset();
    step(1'b0, 1'b0, 32'd0, 0);
    chk("rst_req", obs_req, 32'd0);
    chk("rst_data", obs_data, NOP_INSN);
    step(1'b0, 1'b0, 32'd0, 1);
    chk("rst_restart_addr", obs_addr, 32'h0000_0084);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
             word_t'($urandom_range(0, 1023)) << 2, int'($urandom_range(0, 3)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
